// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one memory port between the CPU pipeline and a host
// port. The CPU has priority, but a host that is refused STARVE_MAX cycles in a row is forced through.
module dmem_arbiter #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              cpu_ren,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic              host_valid,
    input  logic              host_wen,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CPU  = 2'd1,
        S_HOST = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             rd_pend;
    owner_t           rd_owner;

    logic cpu_req;
    logic force_host;
    logic cpu_grant;
    logic host_grant;
    logic rsp_live;

    assign cpu_req    = enable & (cpu_ren | cpu_wen);
    assign force_host = host_valid & (starve_cnt == STARVE_LIM);

    // Reset is synchronous, so the combinational grant is masked while arst_n is low.
    assign cpu_grant  = arst_n & cpu_req & ~force_host;
    assign host_grant = arst_n & host_valid & (force_host | ~cpu_req);

    assign cpu_stall  = arst_n & cpu_req & ~cpu_grant;
    assign host_ready = host_grant;

    always_comb begin
        // NOTE: every output gets a default first; a path that skips one would infer a latch.
        mem_addr  = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        mem_wdata = '0;
        if (cpu_grant) begin
            mem_addr  = cpu_addr;
            mem_wen   = cpu_wen;
            mem_ren   = ~cpu_wen;
            mem_wdata = cpu_wdata;
        end else if (host_grant) begin
            mem_addr  = host_addr;
            mem_wen   = host_wen;
            mem_ren   = ~host_wen;
            mem_wdata = host_wdata;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state      <= S_IDLE;
            starve_cnt <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= OWN_CPU;
        end else begin
            if (cpu_grant) begin
                state <= S_CPU;
            end else if (host_grant) begin
                state <= S_HOST;
            end else begin
                state <= S_IDLE;
            end

            if (host_grant || !host_valid) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            rd_pend <= mem_ren;
            if (mem_ren) begin
                rd_owner <= host_grant ? OWN_HOST : OWN_CPU;
            end
        end
    end

    // A response due in a reset cycle is dropped, so a read in flight never completes.
    assign rsp_live    = arst_n & rd_pend;
    assign cpu_rvalid  = rsp_live & (rd_owner == OWN_CPU);
    assign host_rvalid = rsp_live & (rd_owner == OWN_HOST);
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

    a_one_grant: assert property (@(posedge clk) !(cpu_grant && host_grant));
    a_ready_needs_valid: assert property (@(posedge clk) host_ready |-> host_valid);
    a_owner_matches_state: assert property (@(posedge clk) disable iff (!arst_n)
        rd_pend |-> ((rd_owner == OWN_HOST) == (state == S_HOST)));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a priority/starvation reference model plus
// per-requester read-response queues, driven by directed scenarios and a random phase.
module tb_dmem_arbiter;

    localparam int STARVE = 4;

    typedef struct {
        logic        rst;
        logic        en;
        logic        cr;
        logic        cw;
        logic [63:0] ca;
        logic [63:0] cd;
        logic        hv;
        logic        hw;
        logic [63:0] ha;
        logic [63:0] hd;
    } stim_t;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        enable = 1'b0;
    logic        cpu_ren = 1'b0;
    logic        cpu_wen = 1'b0;
    logic [63:0] cpu_addr = '0;
    logic [63:0] cpu_wdata = '0;
    logic        cpu_stall;
    logic [63:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        host_valid = 1'b0;
    logic        host_wen = 1'b0;
    logic [63:0] host_addr = '0;
    logic [63:0] host_wdata = '0;
    logic        host_ready;
    logic [63:0] host_rdata;
    logic        host_rvalid;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic        mem_ren;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;

    dmem_arbiter #(.DATA_W(64), .ADDR_W(64), .STARVE_MAX(STARVE)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .enable     (enable),
        .cpu_ren    (cpu_ren),
        .cpu_wen    (cpu_wen),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_stall  (cpu_stall),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid),
        .host_valid (host_valid),
        .host_wen   (host_wen),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ready (host_ready),
        .host_rdata (host_rdata),
        .host_rvalid(host_rvalid),
        .mem_addr   (mem_addr),
        .mem_wen    (mem_wen),
        .mem_ren    (mem_ren),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory behind the arbiter: 32 words, one-cycle read latency.
    logic [63:0] mem [32];
    logic        mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 32; i++) mem[i] <= 64'hC0DE_0000_0000_0000 + 64'(i);
            mem_init_done <= 1'b1;
        end else begin
            if (mem_wen) mem[mem_addr[7:3]] <= mem_wdata;
            if (mem_ren) mem_rdata <= mem[mem_addr[7:3]];
        end
    end

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] shadow [32];
    logic [63:0] cpu_q [$];
    logic [63:0] host_q [$];
    int          exp_cnt = 0;
    logic [1:0]  exp_state = 2'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic stim_t mk(input logic en, input logic cr, input logic cw,
                                 input logic [63:0] ca, input logic [63:0] cd,
                                 input logic hv, input logic hw,
                                 input logic [63:0] ha, input logic [63:0] hd);
        stim_t s;
        s.rst = 1'b1; s.en = en; s.cr = cr; s.cw = cw; s.ca = ca; s.cd = cd;
        s.hv = hv; s.hw = hw; s.ha = ha; s.hd = hd;
        return s;
    endfunction

    // One clock cycle: drive at negedge, check against the model, then advance the model.
    task automatic cyc(input stim_t s);
        logic creq, g_cpu, g_host, e_ren, e_wen;
        logic [63:0] e_addr, e_wdata;
        @(negedge clk);
        arst_n = s.rst; enable = s.en; cpu_ren = s.cr; cpu_wen = s.cw;
        cpu_addr = s.ca; cpu_wdata = s.cd; host_valid = s.hv; host_wen = s.hw;
        host_addr = s.ha; host_wdata = s.hd;

        creq = s.en & (s.cr | s.cw);
        g_cpu = 1'b0; g_host = 1'b0;
        if (!s.rst) begin
            g_cpu = 1'b0;
        end else if (exp_cnt == STARVE && s.hv) begin
            g_host = 1'b1;
        end else if (creq) begin
            g_cpu = 1'b1;
        end else if (s.hv) begin
            g_host = 1'b1;
        end
        e_addr = '0; e_wdata = '0; e_ren = 1'b0; e_wen = 1'b0;
        if (g_cpu) begin
            e_addr = s.ca; e_wdata = s.cd; e_wen = s.cw; e_ren = ~s.cw;
        end else if (g_host) begin
            e_addr = s.ha; e_wdata = s.hd; e_wen = s.hw; e_ren = ~s.hw;
        end

        #1;
        check("cpu_stall", cpu_stall, s.rst & creq & ~g_cpu);
        check("host_ready", host_ready, g_host);
        check("mem_ren", mem_ren, e_ren);
        check("mem_wen", mem_wen, e_wen);
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
        check("state", dut.state, exp_state);
        check("starve_cnt", dut.starve_cnt, exp_cnt);
        if (s.rst && cpu_q.size() > 0) begin
            check("cpu_rvalid", cpu_rvalid, 1'b1);
            check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
        end else begin
            check("cpu_rvalid", cpu_rvalid, 1'b0);
            check("cpu_rdata", cpu_rdata, 64'd0);
        end
        if (s.rst && host_q.size() > 0) begin
            check("host_rvalid", host_rvalid, 1'b1);
            check("host_rdata", host_rdata, host_q.pop_front());
        end else begin
            check("host_rvalid", host_rvalid, 1'b0);
            check("host_rdata", host_rdata, 64'd0);
        end

        if (!s.rst) begin
            cpu_q.delete();
            host_q.delete();
            exp_cnt = 0;
            exp_state = 2'd0;
        end else begin
            exp_state = g_cpu ? 2'd1 : (g_host ? 2'd2 : 2'd0);
            if (g_host || !s.hv) exp_cnt = 0;
            else if (exp_cnt < STARVE) exp_cnt++;
            if (e_ren && g_cpu) cpu_q.push_back(shadow[e_addr[7:3]]);
            if (e_ren && g_host) host_q.push_back(shadow[e_addr[7:3]]);
            if (e_wen) shadow[e_addr[7:3]] = e_wdata;
        end
    endtask

    task automatic idle();
        cyc(mk(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0));
    endtask

    initial begin
        stim_t s;
        for (int i = 0; i < 32; i++) shadow[i] = 64'hC0DE_0000_0000_0000 + 64'(i);

        // Reset with both requesters active: nothing may be granted.
        s = mk(1'b1, 1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b0, 64'h18, 64'h0);
        s.rst = 1'b0;
        cyc(s);
        cyc(s);
        check("rst_no_mem_ren", mem_ren, 1'b0);

        // CPU disabled, host loads then reads back 0xA5.
        cyc(mk(1'b0, 1'b1, 1'b0, 64'h40, 64'h0, 1'b1, 1'b1, 64'h8, 64'hA5));
        check("dis_wr_ready", host_ready, 1'b1);
        cyc(mk(1'b0, 1'b1, 1'b0, 64'h40, 64'h0, 1'b1, 1'b0, 64'h8, 64'h0));
        check("dis_rd_ready", host_ready, 1'b1);
        check("dis_stall", cpu_stall, 1'b0);
        idle();
        check("dis_rvalid", host_rvalid, 1'b1);
        check("dis_rdata_a5", host_rdata, 64'hA5);

        // Simultaneous requests with an empty counter: CPU wins.
        cyc(mk(1'b1, 1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b0, 64'h20, 64'h0));
        check("sim_host_ready", host_ready, 1'b0);
        check("sim_cpu_stall", cpu_stall, 1'b0);
        idle();
        check("sim_starve_1", dut.starve_cnt, 64'd1);
        idle();

        // Continuous contention: host forced every fifth cycle.
        for (int i = 0; i < 10; i++) begin
            cyc(mk(1'b1, 1'b1, 1'b0, 64'h10 + 64'(8 * (i % 2)), 64'h0, 1'b1, 1'b0, 64'h28, 64'h0));
            check("starve_ready", host_ready, (i % 5) == 4);
            check("starve_stall", cpu_stall, (i % 5) == 4);
        end
        idle();

        // Read routing: CPU read then host read.
        cyc(mk(1'b1, 1'b1, 1'b0, 64'h30, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0));
        cyc(mk(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h38, 64'h0));
        check("route_cpu_rvalid", cpu_rvalid, 1'b1);
        check("route_cpu_rdata", cpu_rdata, 64'hC0DE_0000_0000_0006);
        check("route_host_early", host_rvalid, 1'b0);
        idle();
        check("route_host_rvalid", host_rvalid, 1'b1);
        check("route_host_rdata", host_rdata, 64'hC0DE_0000_0000_0007);
        check("route_cpu_late", cpu_rvalid, 1'b0);

        // ren and wen together is a write; read it back.
        cyc(mk(1'b1, 1'b1, 1'b1, 64'h48, 64'h1234, 1'b0, 1'b0, 64'h0, 64'h0));
        check("rw_is_write", mem_wen, 1'b1);
        cyc(mk(1'b1, 1'b1, 1'b0, 64'h48, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0));
        check("wr_no_rvalid", cpu_rvalid, 1'b0);
        idle();
        check("rw_readback", cpu_rdata, 64'h1234);

        // Enable falls with a CPU read pending.
        cyc(mk(1'b1, 1'b1, 1'b0, 64'h50, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0));
        cyc(mk(1'b0, 1'b1, 1'b0, 64'h50, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0));
        check("en_fall_rvalid", cpu_rvalid, 1'b1);
        check("en_fall_stall", cpu_stall, 1'b0);
        idle();

        // Reset the cycle after a host read grant.
        cyc(mk(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 1'b1, 1'b0, 64'h58, 64'h0));
        s = mk(1'b1, 1'b1, 1'b0, 64'h10, 64'h0, 1'b1, 1'b0, 64'h58, 64'h0);
        s.rst = 1'b0;
        cyc(s);
        check("rst_flight_rvalid", host_rvalid, 1'b0);
        check("rst_flight_ready", host_ready, 1'b0);
        cyc(s);
        check("rst_state_idle", dut.state, 64'd0);
        s.rst = 1'b1;
        cyc(s);
        check("post_rst_grant", mem_ren, 1'b1);
        check("post_rst_no_rvalid", host_rvalid, 1'b0);
        idle();

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            s = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                   {56'd0, 5'($urandom_range(0, 31)), 3'b000}, {$urandom, $urandom},
                   $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                   {56'd0, 5'($urandom_range(0, 31)), 3'b000}, {$urandom, $urandom});
            s.rst = $urandom_range(0, 39) != 0;
            cyc(s);
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data word width.
REQ-002 SHALL have parameter ADDR_W, default 64, byte address width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive host-denied cycles before the host is forced.
REQ-004 SHALL have these ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk  in  1  sole clock; all state updates on the rising edge.
- arst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- enable  in  1  CPU running; when low, the CPU side is ignored.
- cpu_ren  in  1  pipeline load request.
- cpu_wen  in  1  pipeline store request.
- cpu_addr  in  ADDR_W  pipeline address.
- cpu_wdata  in  DATA_W  pipeline store data.
- cpu_stall  out  1  pipeline request not granted this cycle.
- cpu_rdata  out  DATA_W  load data.
- cpu_rvalid  out  1  cpu_rdata valid.
- host_valid  in  1  host request pending.
- host_wen  in  1  1 means write, 0 means read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_ready  out  1  host request accepted this cycle.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  host_rdata valid.
- mem_addr  out  ADDR_W  memory address.
- mem_wen  out  1  memory write enable.
- mem_ren  out  1  memory read enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_ren.

Function
REQ-005 SHALL define cpu_req as enable & (cpu_ren | cpu_wen). If both cpu_ren and cpu_wen are set, it SHALL be treated as a write.
REQ-006 SHALL grant at most one requester per cycle. The grant is combinational from the current inputs and the registered state.
REQ-007 SHALL use a 2-bit state register: S_IDLE = 0, S_CPU = 1, S_HOST = 2. The state records the previous cycle's grant.
REQ-008 Grant priority SHALL be applied in this order:
- If starve_cnt equals STARVE_MAX and host_valid is high, grant the host.
- Otherwise, if cpu_req is high, grant the CPU.
- Otherwise, if host_valid is high, grant the host.
- Otherwise, no grant.
REQ-009 State transitions SHALL be: next state = S_CPU on a CPU grant, S_HOST on a host grant, S_IDLE on no grant.
REQ-010 starve_cnt SHALL be a counter of width clog2(STARVE_MAX+1). It SHALL:
- increment when host_valid is high and the host is not granted;
- clear to 0 on a host grant or when host_valid is low;
- saturate at STARVE_MAX.
REQ-011 On a grant, mem_addr, mem_wen, mem_ren and mem_wdata SHALL be driven combinationally from the granted requester's fields.
REQ-012 With no grant, mem_wen and mem_ren SHALL be 0. mem_addr and mem_wdata SHALL be 0.
REQ-013 cpu_stall SHALL equal cpu_req & ~cpu_grant. It SHALL be 0 whenever enable is low.
REQ-014 host_ready SHALL equal the host grant, and SHALL be asserted only while host_valid is high.
REQ-015 A read grant SHALL register rd_owner (CPU or host) and rd_pend. One cycle later, the arbiter SHALL:
- assert exactly one of cpu_rvalid or host_rvalid, according to rd_owner;
- drive mem_rdata onto the matching rdata output.
Read latency is therefore 1 cycle.
REQ-016 The rdata output of the non-owner SHALL hold 0 when its rvalid is low.
REQ-017 Write grants SHALL produce no rvalid.
REQ-018 Back-to-back grants SHALL be supported with no bubble. A new grant issued in the same cycle as a response SHALL be allowed.
REQ-019 If enable falls while a CPU read is pending, cpu_rvalid SHALL still be asserted in the next cycle.

Reset
REQ-020 While arst_n is low at a rising clk, the arbiter SHALL set: state = S_IDLE, starve_cnt = 0, rd_pend = 0, rd_owner = CPU.
REQ-021 During reset, all outputs SHALL be 0: no grant, no rvalid, no stall.
REQ-022 A read in flight when reset is asserted SHALL be discarded; no rvalid SHALL follow reset.
REQ-023 The first grant after reset SHALL occur in the first cycle in which arst_n is sampled high.

Verification
REQ-024 Bench scenario, enable=0, host loading:
- Stimulus: enable=0; host writes 0xA5 to addr 0x8 and then reads addr 0x8.
- Response: host_ready=1 on both cycles; host_rvalid=1 with host_rdata=0xA5 one cycle after the read; cpu_stall=0 throughout.
REQ-025 Bench scenario, simultaneous requests:
- Stimulus: enable=1; cpu_ren and host_valid rise together with starve_cnt=0.
- Response: CPU granted; cpu_stall=0; host_ready=0; starve_cnt=1 on the next cycle.
REQ-026 Bench scenario, host starvation:
- Stimulus: continuous cpu_req and continuous host_valid with STARVE_MAX=4.
- Response: CPU granted on cycles 0-3; host granted on cycle 4 with cpu_stall=1; starve_cnt=0 afterwards; the pattern repeats every 5 cycles.
REQ-027 Bench scenario, read routing:
- Stimulus: a CPU read in cycle n, then a host read in cycle n+1.
- Response: cpu_rvalid=1 only in n+1; host_rvalid=1 only in n+2; each carries mem_rdata of its own address.
REQ-028 Bench scenario, reset with a read in flight:
- Stimulus: arst_n driven low in the cycle after a host read grant.
- Response: host_rvalid=0; state=S_IDLE; starve_cnt=0; no grant until arst_n is sampled high.
